// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver sampling each bit at its centre.
// Optional even-parity bit (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 437
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
`ifdef UART_RX_PARITY_EN
  output logic       o_Parity_Err,
`endif
  output logic       o_Frame_Err
);

  localparam logic [10:0] LAST_CNT = 11'(CLKS_PER_BIT - 1);
  localparam logic [10:0] HALF_CNT = 11'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_CLEANUP   = 3'd4,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd6,
`endif
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [10:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          data_d[idx_q]  = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_bad_d = (^data_q) ^ rx_s_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_d  = data_q;
            dv_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
            state_d = S_CLEANUP;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      S_CLEANUP: state_d = S_IDLE;
      // A break must end before the next falling edge can start a frame.
      S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Frame_Err = fe_q;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_q;
  assign o_Rx_Active  = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
`else
  assign o_Rx_Active  = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_STOP);
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core at 16 clocks per bit.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_core;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // 2 sync flops + IDLE detect, half start bit (counts 0..HALF), then the remaining full bits.
  localparam int LAT = 3 + (HALF + 1) + (FRAME_BITS - 1) * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Frame_Err;
`ifdef UART_RX_PARITY_EN
  logic       o_Parity_Err;
`endif

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_Serial (rx),
    .o_Rx_DV     (o_Rx_DV),
    .o_Rx_Byte   (o_Rx_Byte),
    .o_Rx_Active (o_Rx_Active),
`ifdef UART_RX_PARITY_EN
    .o_Parity_Err(o_Parity_Err),
`endif
    .o_Frame_Err (o_Frame_Err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  int   dv_cnt = 0;
  int   fe_cnt = 0;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;
  logic prev_act = 1'b0;
  int   act_len = 0;
  int   last_act_len = 0;
  int   start_cyc = 0;
  bit   lat_chk = 1'b0;

  always @(negedge clk) begin
    if (o_Rx_DV) begin
      dv_cnt++;
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_dv observed=%h expected=none", o_Rx_Byte);
      end
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        total++;
        assert (o_Rx_Byte === exp_e[7:0]) else begin
          bad++;
          $error("FAIL rx_byte observed=%h expected=%h", o_Rx_Byte, exp_e[7:0]);
        end
`ifdef UART_RX_PARITY_EN
        total++;
        assert (o_Parity_Err === exp_e[8]) else begin
          bad++;
          $error("FAIL parity_err observed=%b expected=%b", o_Parity_Err, exp_e[8]);
        end
`endif
      end
      if (lat_chk) begin
        lat_chk = 1'b0;
        total++;
        assert ((cyc - start_cyc) === LAT) else begin
          bad++;
          $error("FAIL dv_latency observed=%0d expected=%0d", cyc - start_cyc, LAT);
        end
      end
      total++;
      assert (prev_dv === 1'b0) else begin
        bad++;
        $error("FAIL dv_width observed=%b expected=%b", prev_dv, 1'b0);
      end
      total++;
      assert (o_Frame_Err === 1'b0) else begin
        bad++;
        $error("FAIL dv_fe_exclusive observed=%b expected=%b", o_Frame_Err, 1'b0);
      end
    end
    if (o_Frame_Err) begin
      fe_cnt++;
      total++;
      assert (prev_fe === 1'b0) else begin
        bad++;
        $error("FAIL fe_width observed=%b expected=%b", prev_fe, 1'b0);
      end
    end
`ifdef UART_RX_PARITY_EN
    if (o_Parity_Err && !o_Rx_DV) begin
      total++;
      bad++;
      $error("FAIL perr_without_dv observed=%b expected=%b", o_Parity_Err, 1'b0);
    end
`endif
    if (o_Rx_Active) act_len++;
    else if (prev_act) begin
      last_act_len = act_len;
      act_len = 0;
    end
    prev_dv  = o_Rx_DV;
    prev_fe  = o_Frame_Err;
    prev_act = o_Rx_Active;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_b);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 8 * CPB && exp_q.size() != 0; i++) tick(1);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] b5a;
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check("rst_dv", o_Rx_DV, 0);
    check("rst_fe", o_Frame_Err, 0);
    check("rst_active", o_Rx_Active, 0);
    check("rst_byte", o_Rx_Byte, 8'h00);
    rst_n = 1'b1;
    tick(2 * CPB);

    exp_q.push_back({1'b0, 8'hA5});
    lat_chk = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(CPB);
    wait_drain("a5_drain");
    check("a5_dv_count", dv_cnt, 1);
    check("a5_active_len", last_act_len, LAT - 3);
    check("a5_no_fe", fe_cnt, 0);
    check("a5_byte_hold", o_Rx_Byte, 8'hA5);

    last_act_len = 0;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch_active_len", last_act_len, HALF + 1);
    check("glitch_active_idle", o_Rx_Active, 0);
    check("glitch_dv_count", dv_cnt, 1);
    check("glitch_fe", fe_cnt, 0);
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(CPB);
    wait_drain("3c_drain");
    check("3c_dv_count", dv_cnt, 2);

    send_frame(8'h00, 1'b0, 1'b0);
    repeat (40) drive_bit(1'b0);
    check("break_fe_count", fe_cnt, 1);
    check("break_dv_count", dv_cnt, 2);
    check("break_byte_kept", o_Rx_Byte, 8'h3C);
    check("break_active", o_Rx_Active, 0);
    rx = 1'b1;
    tick(2 * CPB);
    check("break_end_fe", fe_cnt, 1);
    check("break_end_dv", dv_cnt, 2);
    exp_q.push_back({1'b0, 8'h96});
    send_frame(8'h96, 1'b1, 1'b0);
    tick(CPB);
    wait_drain("after_break_drain");
    check("after_break_dv", dv_cnt, 3);

    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    tick(CPB);
    wait_drain("b2b_drain");
    check("b2b_dv_count", dv_cnt, 5);

    b5a = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b5a[i]);
    rx = b5a[4];
    tick(CPB / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    tick(2);
    check("midrst_dv", o_Rx_DV, 0);
    check("midrst_fe", o_Frame_Err, 0);
    check("midrst_active", o_Rx_Active, 0);
    check("midrst_byte", o_Rx_Byte, 8'h00);
    rst_n = 1'b1;
    tick(3 * CPB);
    check("postrst_dv_count", dv_cnt, 5);
    check("postrst_byte", o_Rx_Byte, 8'h00);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1, 1'b0);
    tick(CPB);
    wait_drain("81_drain");
    check("81_dv_count", dv_cnt, 6);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back({1'b0, 8'h07});
    send_frame(8'h07, 1'b1, 1'b0);
    exp_q.push_back({1'b1, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1);
    tick(CPB);
    wait_drain("parity_drain");
    check("parity_dv_count", dv_cnt, 8);
`endif

    tick(2 * CPB);
    check("final_fe_count", fe_cnt, 1);
    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 437, meaning clocks per serial bit (range 4..2047).
REQ-002 SHALL have port i_Clock, input, 1, the only clock; all logic is on its rising edge.
REQ-003 SHALL have port i_Rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port i_Rx_Serial, input, 1, asynchronous serial line, idle high.
REQ-005 SHALL have port o_Rx_DV, output, 1, one-cycle pulse: o_Rx_Byte is valid.
REQ-006 SHALL have port o_Rx_Byte, output, 8, last good received byte, LSB first on the wire.
REQ-007 SHALL have port o_Rx_Active, output, 1, high from start-bit detect to return to IDLE.
REQ-008 SHALL have port o_Frame_Err, output, 1, one-cycle pulse: stop bit sampled low.

Function
REQ-009 SHALL pass i_Rx_Serial through a 2-flop synchronizer; rx_s below means the second-stage output.
REQ-010 SHALL use an 11-bit clock counter, a 3-bit bit index and states IDLE, START, DATA, STOP, CLEANUP and WAIT_HIGH.
REQ-011 IDLE: counter=0, index=0; rx_s==0 -> START; otherwise stay.
REQ-012 START: counter increments until it reaches (CLKS_PER_BIT-1)/2, truncated, which is the mid-bit point.
  - At that count with rx_s==0: counter=0, go to DATA.
  - At that count with rx_s==1: false start; go to IDLE with no output pulse.
REQ-013 DATA: at count CLKS_PER_BIT-1, the byte register stores rx_s at [index] and counter=0.
  - Index<7: index+1, stay in DATA.
  - Index==7: index=0, go to STOP.
  - This samples each data bit at its centre.
REQ-014 STOP: at count CLKS_PER_BIT-1, counter=0.
  - rx_s==1: o_Rx_Byte is loaded from the byte register, o_Rx_DV=1 on the next cycle, go to CLEANUP.
  - rx_s==0: o_Frame_Err=1 on the next cycle, o_Rx_Byte is unchanged, go to WAIT_HIGH.
REQ-015 CLEANUP SHALL last exactly one cycle, then go to IDLE.
REQ-016 WAIT_HIGH SHALL stay while rx_s==0 (break condition), go to IDLE when rx_s==1, and never start a new frame from a break.
REQ-017 o_Rx_DV and o_Frame_Err SHALL be high for exactly one cycle per frame, are mutually exclusive, and never both assert.
REQ-018 o_Rx_Active SHALL be 1 in START, DATA and STOP, and 0 in IDLE, CLEANUP and WAIT_HIGH.
REQ-019 Latency SHALL be: o_Rx_DV rises 2 (synchronizer) + 1 cycles after the stop-bit mid-sample edge on i_Rx_Serial.
REQ-020 Back-to-back frames SHALL be received: a start edge arriving during CLEANUP is detected in the following IDLE cycle without losing a frame.
REQ-021 An undefined state encoding SHALL go to IDLE on the next clock.

Reset
REQ-022 While i_Rst_n==0 at a clock edge, the block SHALL be in the following reset state:
  - state=IDLE, counter=0, index=0.
  - byte register and o_Rx_Byte=8'h00.
  - o_Rx_DV=0, o_Frame_Err=0, o_Rx_Active=0.
  - both synchronizer flops=1, and o_Parity_Err=0 when present.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, reception resumes from the next falling edge.

Configuration
REQ-024 With macro UART_RX_PARITY_EN defined, the block SHALL add state PARITY and output o_Parity_Err (output, 1, one-cycle pulse).
  - PARITY sits between DATA and STOP and samples one even-parity bit at mid-bit.
  - On a parity mismatch with a valid stop bit, o_Parity_Err pulses together with o_Rx_DV, and o_Rx_Byte still updates.
  - A frame is 11 bits.
REQ-025 Without UART_RX_PARITY_EN, the block SHALL have no PARITY state and no o_Parity_Err port, and a frame is 10 bits (8N1).

Verification
REQ-026 The bench SHALL cover these scenarios; unless stated, CLKS_PER_BIT=16 and the line idles high:
  - Send 8'hA5 (8N1) -> one o_Rx_DV pulse, o_Rx_Byte=8'hA5, o_Frame_Err never high, o_Rx_Active high for roughly 9.5 bit times.
  - Drive a 5-cycle low glitch on an idle line -> no o_Rx_DV, no o_Frame_Err; o_Rx_Active pulses then returns to 0; a following 8'h3C is received correctly.
  - Send 8'h00 with the stop bit forced low, then hold the line low for 40 bits -> one o_Frame_Err pulse, no o_Rx_DV, o_Rx_Byte keeps its prior value, no further pulses until the line is high and a new frame arrives.
  - Send 8'h00 then 8'hFF with zero idle gap -> two o_Rx_DV pulses with bytes 8'h00 and 8'hFF, in order.
  - Assert i_Rst_n=0 during bit 4 of 8'h5A, release, then send 8'h81 -> no pulse for 8'h5A, o_Rx_Byte=8'h81, all outputs 0 during reset.
  - With UART_RX_PARITY_EN, send 8'h07 with parity bit 1 (correct) and then parity bit 0 (wrong) -> first frame o_Rx_DV only, second frame o_Rx_DV and o_Parity_Err together.
